hazard_controller: RTL and testbench



---
 rtl/hazard_controller.sv | 157 +++++++++++++++
 tb/tb_hazard_controller.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: decode forwarding selects, load-use bubbles, branch squash
// and a memory-busy freeze with watchdog. Optional counters: define HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rsD,
  input  logic [4:0]  rtD,
  input  logic        useRsD,
  input  logic        useRtD,
  input  logic        branchD,
  input  logic        branchTakenD,
  input  logic [4:0]  writeRegE,
  input  logic        regWriteE,
  input  logic        mem2RegE,
  input  logic        memWriteE,
  input  logic [4:0]  writeRegM,
  input  logic        regWriteM,
  input  logic        memReady,
  output logic [1:0]  fad,
  output logic [1:0]  fbd,
  output logic        stallF,
  output logic        stallD,
  output logic        flushD,
  output logic        flushE,
  output logic        pcSelF,
  output logic        freeze,
  output logic        memError,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount,
  output logic        state_dbg
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_error_q, mem_error_d;
  logic       mem2reg_m_q, mem2reg_m_d;
  logic       mem_write_m_q, mem_write_m_d;
  logic       mem_op_m, lu_haz, freeze_int, live;
  logic [1:0] fad_raw, fbd_raw;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] wr_e, input logic rw_e, input logic m2r_e,
    input logic [4:0] wr_m, input logic rw_m, input logic m2r_m
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (src != 5'd0 && rw_e && wr_e == src && !m2r_e) sel = 2'd1;
    else if (src != 5'd0 && rw_m && wr_m == src)      sel = m2r_m ? 2'd2 : 2'd3;
    return sel;
  endfunction

  assign mem_op_m = mem2reg_m_q | mem_write_m_q;
  assign live     = ~rst;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_error_d = mem_error_q;
    freeze_int  = 1'b0;
    case (state_q)
      RUN: begin
        if (mem_op_m && !memReady) begin
          freeze_int = 1'b1;
          wait_cnt_d = 8'd1;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        freeze_int = !memReady && (wait_cnt_q < TIMEOUT_C);
        if (memReady) begin
          wait_cnt_d = 8'd0;
          state_d    = RUN;
        end else if (wait_cnt_q >= TIMEOUT_C) begin
          // Give up: release the pipeline and let the access retire with bad data.
          wait_cnt_d  = 8'd0;
          mem_error_d = 1'b1;
          state_d     = RUN;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    mem2reg_m_d   = freeze_int ? mem2reg_m_q   : mem2RegE;
    mem_write_m_d = freeze_int ? mem_write_m_q : memWriteE;
    lu_haz  = regWriteE && mem2RegE && (writeRegE != 5'd0) &&
              ((useRsD && writeRegE == rsD) || (useRtD && writeRegE == rtD));
    fad_raw = fwd_sel(rsD, writeRegE, regWriteE, mem2RegE, writeRegM, regWriteM, mem2reg_m_q);
    fbd_raw = fwd_sel(rtD, writeRegE, regWriteE, mem2RegE, writeRegM, regWriteM, mem2reg_m_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      mem_error_q   <= 1'b0;
      mem2reg_m_q   <= 1'b0;
      mem_write_m_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_error_q   <= mem_error_d;
      mem2reg_m_q   <= mem2reg_m_d;
      mem_write_m_q <= mem_write_m_d;
    end
  end

  // Reset forces every combinational output low, whatever the datapath presents.
  assign fad       = live ? fad_raw : 2'd0;
  assign fbd       = live ? fbd_raw : 2'd0;
  assign freeze    = live & freeze_int;
  assign stallF    = live & (lu_haz | freeze_int);
  assign stallD    = live & (lu_haz | freeze_int);
  assign flushE    = live & lu_haz & ~freeze_int;
  assign flushD    = live & branchD & branchTakenD & ~lu_haz & ~freeze_int;
  assign pcSelF    = flushD;
  assign memError  = mem_error_q;
  assign state_dbg = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (stallD && stall_count_q != 32'hFFFF_FFFF) stall_count_d = stall_count_q + 32'd1;
    if ((flushD || flushE) && flush_count_q != 32'hFFFF_FFFF) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stallCount = stall_count_q;
  assign flushCount = flush_count_q;
`else
  assign stallCount = 32'd0;
  assign flushCount = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed plan scenarios followed by random cycles,
// all checked against a cycle-level reference model of the hazard rules.
module tb_hazard_controller;
  localparam int MEM_TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rsD, rtD, writeRegE, writeRegM;
  logic        useRsD, useRtD, branchD, branchTakenD;
  logic        regWriteE, mem2RegE, memWriteE, regWriteM, memReady;
  logic [1:0]  fad, fbd;
  logic        stallF, stallD, flushD, flushE, pcSelF, freeze, memError, state_dbg;
  logic [31:0] stallCount, flushCount;

  int tests = 0;
  int fails = 0;
  logic [12:0] exp_q[$];

  // reference model state
  logic        m_m2r, m_mw, m_err;
  int          m_wait;
  logic [31:0] m_stall, m_flush;

  // values observed at the last sample point
  logic [1:0]  s_fad, s_fbd;
  logic        s_stall, s_flushE, s_pcsel, s_freeze, s_err;
  logic [31:0] s_stall_cnt;

  hazard_controller #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .useRsD(useRsD), .useRtD(useRtD),
    .branchD(branchD), .branchTakenD(branchTakenD), .writeRegE(writeRegE),
    .regWriteE(regWriteE), .mem2RegE(mem2RegE), .memWriteE(memWriteE),
    .writeRegM(writeRegM), .regWriteM(regWriteM), .memReady(memReady),
    .fad(fad), .fbd(fbd), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .flushE(flushE), .pcSelF(pcSelF), .freeze(freeze), .memError(memError),
    .stallCount(stallCount), .flushCount(flushCount), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                       input logic urt, input logic br, input logic tk);
    rsD = rs; rtD = rt; useRsD = urs; useRtD = urt; branchD = br; branchTakenD = tk;
  endtask

  task automatic set_e(input logic [4:0] wr, input logic rw, input logic m2r, input logic mw);
    writeRegE = wr; regWriteE = rw; mem2RegE = m2r; memWriteE = mw;
  endtask

  task automatic set_m(input logic [4:0] wr, input logic rw);
    writeRegM = wr; regWriteM = rw;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 0, 0, 0); set_e(0, 0, 0, 0); set_m(0, 0); memReady = 1'b1;
  endtask

  task automatic model_reset();
    m_m2r = 0; m_mw = 0; m_err = 0; m_wait = 0; m_stall = 0; m_flush = 0;
  endtask

  function automatic logic [1:0] ref_fwd(input logic [4:0] src);
    if (src != 0 && regWriteE && writeRegE == src && !mem2RegE) return 2'd1;
    if (src != 0 && regWriteM && writeRegM == src) return m_m2r ? 2'd2 : 2'd3;
    return 2'd0;
  endfunction

  // One pipeline cycle: predict, sample at negedge, compare, advance the model.
  task automatic step(input string tag);
    logic mem_op, lu, frz, stall, fle, fld;
    logic [31:0] exp_sc, exp_fc;
    mem_op = m_m2r | m_mw;
    frz    = mem_op && !memReady && (m_wait < MEM_TIMEOUT);
    lu     = regWriteE && mem2RegE && writeRegE != 0 &&
             ((useRsD && writeRegE == rsD) || (useRtD && writeRegE == rtD));
    stall  = lu | frz;
    fle    = lu & !frz;
    fld    = branchD & branchTakenD & !lu & !frz;
    exp_q.push_back({ref_fwd(rsD), ref_fwd(rtD), stall, stall, fld, fle, fld, frz, m_err});
`ifdef HAZARD_PERF_CNT_EN
    exp_sc = m_stall; exp_fc = m_flush;
`else
    exp_sc = 0; exp_fc = 0;
`endif
    @(negedge clk);
    check(tag, {19'd0, fad, fbd, stallF, stallD, flushD, flushE, pcSelF, freeze, memError},
          {19'd0, exp_q.pop_front()});
    check({tag, "_stallcnt"}, stallCount, exp_sc);
    check({tag, "_flushcnt"}, flushCount, exp_fc);
    s_fad = fad; s_fbd = fbd; s_stall = stallD; s_flushE = flushE; s_pcsel = pcSelF;
    s_freeze = freeze; s_err = memError; s_stall_cnt = stallCount;
    if (frz) m_wait++;
    else begin
      if (mem_op && !memReady) m_err = 1;
      m_wait = 0;
    end
    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
    if ((fld || fle) && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (!frz) begin m_m2r = mem2RegE; m_mw = memWriteE; end
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    int bias;
    rst = 1'b1;
    idle();
    model_reset();
    #3;
    check("rst_outs", {19'd0, fad, fbd, stallF, stallD, flushD, flushE, pcSelF, freeze, memError}, 0);
    check("rst_stallcnt", stallCount, 0);
    check("rst_state", {31'd0, state_dbg}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // forwarding from execute, then register 0 never matches
    set_e(3, 1, 0, 0); set_d(3, 0, 1, 0, 0, 0); step("fwd_e");
    check("fad_from_e", {30'd0, s_fad}, 1);
    check("fwd_e_nostall", {31'd0, s_stall}, 0);
    set_e(0, 1, 0, 0); set_d(0, 0, 1, 0, 0, 0); step("fwd_r0");
    check("fad_r0", {30'd0, s_fad}, 0);

    // load-use: one bubble, then memDataM forwarded
    set_e(2, 1, 1, 0); set_d(0, 2, 0, 1, 0, 0); step("lu");
    check("lu_stall", {31'd0, s_stall}, 1);
    check("lu_flushE", {31'd0, s_flushE}, 1);
    set_e(0, 0, 0, 0); set_m(2, 1); step("lu_next");
    check("lu_fbd_mem", {30'd0, s_fbd}, 2);
    check("lu_next_nostall", {31'd0, s_stall}, 0);
`ifdef HAZARD_PERF_CNT_EN
    check("lu_stallcount", s_stall_cnt, 1);
`else
    check("lu_stallcount", s_stall_cnt, 0);
`endif

    // taken branch, then taken branch delayed by a load-use stall
    set_m(0, 0); set_d(0, 0, 0, 0, 1, 1); step("br");
    check("br_pcsel", {31'd0, s_pcsel}, 1);
    set_e(5, 1, 1, 0); set_d(5, 0, 1, 0, 1, 1); step("br_lu");
    check("br_lu_pcsel", {31'd0, s_pcsel}, 0);
    set_e(0, 0, 0, 0); set_m(5, 1); step("br_after");
    check("br_after_pcsel", {31'd0, s_pcsel}, 1);

    // memory busy for three cycles
    idle(); set_e(4, 1, 1, 0); step("ld3_e");
    set_e(0, 0, 0, 0); memReady = 1'b0; n = 0;
    repeat (3) begin step("frz3"); n += int'(s_freeze); end
    memReady = 1'b1; step("frz3_rel");
    check("frz3_count", n, 3);
    check("frz3_released", {31'd0, s_freeze}, 0);
    check("frz3_noerr", {31'd0, s_err}, 0);

    // memory never answers: watchdog releases and flags the error
    set_e(6, 1, 1, 0); step("ldto_e");
    set_e(0, 0, 0, 0); memReady = 1'b0; n = 0;
    repeat (17) begin step("frz_to"); n += int'(s_freeze); end
    check("timeout_count", n, MEM_TIMEOUT);
    memReady = 1'b1; step("to_after");
    check("timeout_err", {31'd0, s_err}, 1);
    set_e(1, 1, 1, 0); step("to_sticky1");
    set_e(0, 0, 0, 0); step("to_sticky2");
    check("err_sticky", {31'd0, s_err}, 1);

    // asynchronous reset in the middle of a wait
    set_e(7, 1, 1, 0); step("ldrst_e");
    set_e(0, 0, 0, 0); memReady = 1'b0;
    repeat (5) step("wait5");
    set_e(3, 1, 0, 0); set_d(3, 3, 1, 1, 1, 1); set_m(3, 1);
    #1 rst = 1'b1;
    #2;
    check("rstw_outs", {19'd0, fad, fbd, stallF, stallD, flushD, flushE, pcSelF, freeze, memError}, 0);
    check("rstw_stallcnt", stallCount, 0);
    check("rstw_flushcnt", flushCount, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    idle(); set_e(8, 1, 1, 0); step("ld_post_rst");
    set_e(0, 0, 0, 0); step("ld_post_rst_m");
    check("post_rst_nofreeze", {31'd0, s_freeze}, 0);

    // random traffic with varying memory readiness
    for (int ph = 0; ph < 4; ph++) begin
      bias = 3 + ph;
      repeat (100) begin
        set_d(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        set_e(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 5) == 0);
        set_m(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        memReady = $urandom_range(0, 7) < bias;
        step("rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
